// File: rtl/mem_miss_arbiter.sv
// Arbitrates single-ported main memory between I/D-cache block fills and D-cache write-through stores.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternating I/D tie-break instead of fixed I-over-D priority.
module mem_miss_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_miss,
    input  logic [ADDR_W-1:0]                  i_miss_addr,
    input  logic                               d_miss,
    input  logic [ADDR_W-1:0]                  d_miss_addr,
    input  logic                               d_wr_req,
    input  logic [ADDR_W-1:0]                  d_wr_addr,
    input  logic [DATA_W-1:0]                  d_wr_data,
    output logic                               mem_enable,
    output logic                               mem_wr,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_data_in,
    input  logic [DATA_W-1:0]                  mem_data_out,
    input  logic                               mem_data_valid,
    output logic [DATA_W-1:0]                  fill_data,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic                               i_fill_we,
    output logic                               d_fill_we,
    output logic                               i_fill_done,
    output logic                               d_fill_done,
    output logic                               d_wr_ack,
    output logic                               stall,
    output logic                               busy
);
    localparam int WORD_W  = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W   = WORD_W + 1;
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int OFF_W   = WORD_W + BYTE_SH;
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0]  ISSUE_END  = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   ic_r;
    logic [WORD_W-1:0]  rc_r;
    logic               owner_d_r;
    logic [ADDR_W-1:0]  base_r;
    logic               grant_i_s;
    logic               grant_d_s;
    logic               tie_s;
    logic [ADDR_W-1:0]  miss_base_s;
    logic               fill_hit_s;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [WORD_W-1:0] idx);
        word_addr = base + (ADDR_W'(idx) << BYTE_SH);
    endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d_r;

    // Remembers which miss won the most recent contested grant; uncontested grants leave it alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_d_r <= 1'b1;
        end else if (state_r == IDLE && !d_wr_req && tie_s) begin
            last_d_r <= grant_d_s;
        end else begin
            last_d_r <= last_d_r;
        end
    end
`endif

    // Miss arbitration; a pending store pre-empts both misses inside the FSM.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        tie_s     = i_miss & d_miss;
        if (tie_s) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_i_s = last_d_r;
            grant_d_s = ~last_d_r;
`else
            grant_i_s = 1'b1;
`endif
        end else if (i_miss) begin
            grant_i_s = 1'b1;
        end else if (d_miss) begin
            grant_d_s = 1'b1;
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    assign miss_base_s = (grant_d_s ? d_miss_addr : i_miss_addr) & BLOCK_MASK;
    assign fill_hit_s  = (state_r == FILL) & mem_data_valid;
    assign fill_data   = mem_data_out;
    assign fill_word   = rc_r;
    assign i_fill_we   = fill_hit_s & ~owner_d_r;
    assign d_fill_we   = fill_hit_s & owner_d_r;
    assign stall       = i_miss | d_miss | (d_wr_req & ~d_wr_ack);

    // Main sequencer; memory-side outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            ic_r        <= '0;
            rc_r        <= '0;
            owner_d_r   <= 1'b0;
            base_r      <= '0;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            i_fill_done <= 1'b0;
            d_fill_done <= 1'b0;
            d_wr_ack    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            i_fill_done <= 1'b0;
            d_fill_done <= 1'b0;
            d_wr_ack    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (d_wr_req) begin
                        state_r     <= WRITE;
                        busy        <= 1'b1;
                        mem_enable  <= 1'b1;
                        mem_wr      <= 1'b1;
                        mem_addr    <= d_wr_addr;
                        mem_data_in <= d_wr_data;
                        d_wr_ack    <= 1'b1;
                    end else if (grant_i_s || grant_d_s) begin
                        state_r     <= FILL;
                        busy        <= 1'b1;
                        owner_d_r   <= grant_d_s;
                        base_r      <= miss_base_s;
                        mem_enable  <= 1'b1;
                        mem_wr      <= 1'b0;
                        mem_addr    <= miss_base_s;
                        mem_data_in <= '0;
                        ic_r        <= CNT_W'(1);
                        rc_r        <= '0;
                    end else begin
                        state_r     <= IDLE;
                        busy        <= 1'b0;
                        mem_enable  <= 1'b0;
                        mem_wr      <= 1'b0;
                        mem_addr    <= '0;
                        mem_data_in <= '0;
                    end
                end
                WRITE: begin
                    state_r     <= IDLE;
                    busy        <= 1'b0;
                    mem_enable  <= 1'b0;
                    mem_wr      <= 1'b0;
                    mem_addr    <= '0;
                    mem_data_in <= '0;
                end
                FILL: begin
                    if (ic_r < ISSUE_END) begin
                        mem_enable <= 1'b1;
                        mem_addr   <= word_addr(base_r, ic_r[WORD_W-1:0]);
                        ic_r       <= ic_r + CNT_W'(1);
                    end else begin
                        mem_enable <= 1'b0;
                        mem_addr   <= '0;
                    end
                    if (mem_data_valid) begin
                        rc_r <= rc_r + WORD_W'(1);
                        if (rc_r == LAST_WORD) begin
                            state_r     <= DONE;
                            mem_enable  <= 1'b0;
                            mem_addr    <= '0;
                            i_fill_done <= ~owner_d_r;
                            d_fill_done <= owner_d_r;
                        end else begin
                            state_r <= FILL;
                        end
                    end else begin
                        state_r <= FILL;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    mem_enable <= 1'b0;
                    ic_r       <= '0;
                    rc_r       <= '0;
                end
                default: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    mem_enable <= 1'b0;
                    mem_wr     <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    localparam int WD_LIMIT = 4 * MEM_LATENCY;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);
    logic [WD_W-1:0] wd_cnt_r;

    // Simulation watchdog: a fill starved of read data points at a memory-side fault.
    always_ff @(posedge clk) begin
        if (!rst || state_r != FILL || mem_data_valid) begin
            wd_cnt_r <= '0;
        end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
            if (wd_cnt_r == WD_W'(WD_LIMIT - 1)) begin
                $error("mem_miss_arbiter: no read data for %0d cycles during fill", WD_LIMIT);
            end
        end
    end
`endif
endmodule
